// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory port between the instruction fetch bus (ibus)
//   and the load/store bus (dbus). One transaction is in flight at a time.
//   The winner's request fields are latched at grant, and the memory response
//   is registered back to the winner as a single-cycle ok pulse.
//   Dbus has priority. A starvation counter forces an ibus grant after
//   STARVE_LIMIT consecutive dbus grants that were made while ibus was waiting.
//
// Ports
//   clk, reset          core clock, async active-low reset
//   i_valid/i_addr      fetch read request (held until i_ok)
//   i_ok/i_data         fetch completion pulse + instruction word
//   d_valid/d_addr/
//   d_size/d_strobe/
//   d_wdata             load/store request (held until d_ok)
//   d_ok/d_data         load/store completion pulse + raw 64-bit beat
//   m_valid/m_addr/
//   m_size/m_strobe/
//   m_wdata             latched request to memory (held until m_ok)
//   m_ok/m_data         memory completion + read data
//
// state  | meaning
// IDLE   | arbitrate between pending requests
// BUSY_I | ibus transaction outstanding at memory
// BUSY_D | dbus transaction outstanding at memory
// RESP   | ok pulse to the winner; forced idle bubble follows
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ok,
  input  logic [63:0] m_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_addr_q, m_addr_d;
  logic [2:0]  m_size_q, m_size_d;
  logic [7:0]  m_strobe_q, m_strobe_d;
  logic [63:0] m_wdata_q, m_wdata_d;
  logic        i_ok_q, i_ok_d;
  logic [31:0] i_data_q, i_data_d;
  logic        d_ok_q, d_ok_d;
  logic [63:0] d_data_q, d_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      m_valid_q    <= 1'b0;
      m_addr_q     <= '0;
      m_size_q     <= '0;
      m_strobe_q   <= '0;
      m_wdata_q    <= '0;
      i_ok_q       <= 1'b0;
      i_data_q     <= '0;
      d_ok_q       <= 1'b0;
      d_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      m_valid_q    <= m_valid_d;
      m_addr_q     <= m_addr_d;
      m_size_q     <= m_size_d;
      m_strobe_q   <= m_strobe_d;
      m_wdata_q    <= m_wdata_d;
      i_ok_q       <= i_ok_d;
      i_data_q     <= i_data_d;
      d_ok_q       <= d_ok_d;
      d_data_q     <= d_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    m_valid_d    = m_valid_q;
    m_addr_d     = m_addr_q;
    m_size_d     = m_size_q;
    m_strobe_d   = m_strobe_q;
    m_wdata_d    = m_wdata_q;
    i_ok_d       = 1'b0;
    i_data_d     = i_data_q;
    d_ok_d       = 1'b0;
    d_data_d     = d_data_q;

    unique case (state_q)
      IDLE: begin
        // dbus wins unless ibus is also waiting and has been passed over
        // STARVE_LIMIT times in a row.
        if (d_valid && (!i_valid || (starve_cnt_q < LIMIT))) begin
          state_d    = BUSY_D;
          m_valid_d  = 1'b1;
          m_addr_d   = d_addr;
          m_size_d   = d_size;
          m_strobe_d = d_strobe;
          m_wdata_d  = d_wdata;
          // Only a dbus win over a waiting ibus counts towards starvation.
          if (i_valid) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (i_valid) begin
          state_d      = BUSY_I;
          starve_cnt_d = '0;
          m_valid_d    = 1'b1;
          m_addr_d     = i_addr;
          m_size_d     = 3'd2;
          m_strobe_d   = 8'h00;
          m_wdata_d    = '0;
        end
      end
      BUSY_I: begin
        if (m_ok) begin
          state_d   = RESP;
          m_valid_d = 1'b0;
          i_ok_d    = 1'b1;
          // Pick the 32-bit half of the beat that holds the fetched word.
          i_data_d  = m_addr_q[2] ? m_data[63:32] : m_data[31:0];
        end
      end
      BUSY_D: begin
        if (m_ok) begin
          state_d   = RESP;
          m_valid_d = 1'b0;
          d_ok_d    = 1'b1;
          d_data_d  = m_data;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_size   = m_size_q;
  assign m_strobe = m_strobe_q;
  assign m_wdata  = m_wdata_q;
  assign i_ok     = i_ok_q;
  assign i_data   = i_data_q;
  assign d_ok     = d_ok_q;
  assign d_data   = d_data_q;

endmodule
